// File: rtl/vdma_pkg.sv
`timescale 1ns/1ps
// Shared types for the VDMA burst requester: FSM state encoding and
// command-length sizing.
package vdma_pkg;

    localparam int CMD_LEN_W = 8;

    typedef enum logic [3:0] {
        S_IDLE,
        S_BASE,
        S_GAP,
        S_CMD_F,
        S_WAIT_F,
        S_CMD_T,
        S_WAIT_T,
        S_NULLT,
        S_DONE
    } state_t;

    // Exact log2 for a power-of-two burst length (elaboration-time only).
    function automatic int log2_pow2(input int n);
        int r;
        r = 0;
        for (int i = 0; i < 31; i++) begin
            if ((1 << i) == n) r = i;
        end
        return r;
    endfunction

endpackage

// File: rtl/vdma_burst_requester.sv
`timescale 1ns/1ps
// Splits each frame line into full bursts plus one tail (real or null) and
// drives the request levels/commands that step the VDMA address generator.
module vdma_burst_requester
    import vdma_pkg::*;
#(
    parameter int BURST_LEN  = 128,
    parameter int LSIZE      = 12,
    parameter int VSIZE      = 12,
    parameter int GAP_CYCLES = 3
) (
    input  logic                 clock,
    input  logic                 rst_n,
    input  logic                 frame_start,
    input  logic [LSIZE-1:0]     line_beats,
    input  logic [VSIZE-1:0]     frame_lines,
    output logic                 new_base,
    output logic                 burst_req,
    output logic                 tail_req,
    output logic                 cmd_valid,
    input  logic                 cmd_ready,
    output logic [CMD_LEN_W-1:0] cmd_len,
    input  logic                 xfer_done,
    output logic                 frame_busy,
    output logic                 frame_done,
    output logic [VSIZE-1:0]     line_cnt
);

    localparam int LOG2_BL = log2_pow2(BURST_LEN);
    localparam int GAP_W   = $clog2(GAP_CYCLES + 1);

    state_t                 r_state;
    state_t                 w_state_nxt;
    logic [GAP_W-1:0]       r_gap_cnt;
    logic [LSIZE-1:0]       r_burst_idx;
    logic [VSIZE-1:0]       r_line_cnt;
    logic [LSIZE-1:0]       r_full_cnt;
    logic [CMD_LEN_W-1:0]   r_rem;
    logic [VSIZE-1:0]       r_frame_lines;
    logic                   r_empty;

    logic [LSIZE-1:0]       w_full_cnt;
    logic [LSIZE-1:0]       w_rem_full;
    logic                   w_gap_last;

    assign w_full_cnt = line_beats >> LOG2_BL;
    assign w_rem_full = line_beats & LSIZE'(BURST_LEN - 1);
    assign w_gap_last = (r_gap_cnt == GAP_W'(GAP_CYCLES - 1));
    assign line_cnt   = r_line_cnt;

    always_ff @(posedge clock or negedge rst_n) begin
        if (!rst_n) r_state <= S_IDLE;
        else        r_state <= w_state_nxt;
    end

    // The line/burst decision is taken in the last GAP cycle rather than in a
    // separate cycle, so a command lands exactly GAP_CYCLES after the requests drop.
    always_comb begin
        w_state_nxt = r_state;
        new_base    = 1'b0;
        burst_req   = 1'b0;
        tail_req    = 1'b0;
        cmd_valid   = 1'b0;
        cmd_len     = '0;
        frame_done  = 1'b0;
        frame_busy  = (r_state != S_IDLE) && (r_state != S_DONE);
        case (r_state)
            S_IDLE: begin
                if (frame_start) w_state_nxt = S_BASE;
            end
            S_BASE: begin
                new_base    = 1'b1;
                w_state_nxt = S_GAP;
            end
            S_GAP: begin
                if (w_gap_last) begin
                    if (r_empty || (r_line_cnt == r_frame_lines)) w_state_nxt = S_DONE;
                    else if (r_burst_idx < r_full_cnt)             w_state_nxt = S_CMD_F;
                    else if (r_rem != '0)                          w_state_nxt = S_CMD_T;
                    else                                           w_state_nxt = S_NULLT;
                end
            end
            S_CMD_F: begin
                burst_req = 1'b1;
                cmd_valid = 1'b1;
                cmd_len   = CMD_LEN_W'(BURST_LEN - 1);
                if (cmd_ready) w_state_nxt = S_WAIT_F;
            end
            S_WAIT_F: begin
                burst_req = 1'b1;
                if (xfer_done) w_state_nxt = S_GAP;
            end
            S_CMD_T: begin
                tail_req  = 1'b1;
                cmd_valid = 1'b1;
                cmd_len   = r_rem - CMD_LEN_W'(1);
                if (cmd_ready) w_state_nxt = S_WAIT_T;
            end
            S_WAIT_T: begin
                tail_req = 1'b1;
                if (xfer_done) w_state_nxt = S_GAP;
            end
            S_NULLT: begin
                tail_req    = 1'b1;
                w_state_nxt = S_GAP;
            end
            S_DONE: begin
                frame_done  = 1'b1;
                w_state_nxt = S_IDLE;
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clock or negedge rst_n) begin
        if (!rst_n) begin
            r_gap_cnt   <= '0;
            r_burst_idx <= '0;
            r_line_cnt  <= '0;
        end else begin
            r_gap_cnt <= (r_state == S_GAP) ? r_gap_cnt + GAP_W'(1) : '0;
            case (r_state)
                S_IDLE: begin
                    if (frame_start) begin
                        r_burst_idx <= '0;
                        r_line_cnt  <= '0;
                    end
                end
                S_WAIT_F: begin
                    if (xfer_done) r_burst_idx <= r_burst_idx + LSIZE'(1);
                end
                S_WAIT_T: begin
                    if (xfer_done) begin
                        r_burst_idx <= '0;
                        r_line_cnt  <= r_line_cnt + VSIZE'(1);
                    end
                end
                S_NULLT: begin
                    r_burst_idx <= '0;
                    r_line_cnt  <= r_line_cnt + VSIZE'(1);
                end
                default: ;
            endcase
        end
    end

    // Frame geometry is only consulted after a frame has been accepted.
    always_ff @(posedge clock) begin
        if ((r_state == S_IDLE) && frame_start) begin
            r_full_cnt    <= w_full_cnt;
            r_rem         <= CMD_LEN_W'(w_rem_full);
            r_frame_lines <= frame_lines;
            r_empty       <= (line_beats == '0) || (frame_lines == '0);
        end
    end

endmodule
